// File: rtl/qpp_pkg.sv
// ---------------------------------------------------------------------------
// qpp_pkg
//
// Shared constants and types for the QPP interleaver index generator.
//
// Contents:
//   IDX_W              width of every index / modular quantity (14 bits)
//   K_SMALL, K_LARGE   the two supported block sizes (1056, 6144)
//   F1_*, F2_*         QPP polynomial coefficients for each block size
//   G0_*               first difference pi(1) - pi(0) = (f1 + f2) mod K
//   D_*                second difference 2*f2 mod K (constant step of g)
//   state_t            FSM state encoding {IDLE, RUN}
//   sel_k/sel_g0/sel_d constant selection by the one-bit block-size select
// ---------------------------------------------------------------------------
package qpp_pkg;

    localparam int IDX_W = 14;

    typedef logic [IDX_W-1:0] idx_t;

    // Block sizes and polynomial coefficients.
    localparam idx_t K_SMALL  = IDX_W'(1056);
    localparam idx_t K_LARGE  = IDX_W'(6144);
    localparam idx_t F1_SMALL = IDX_W'(17);
    localparam idx_t F2_SMALL = IDX_W'(66);
    localparam idx_t F1_LARGE = IDX_W'(263);
    localparam idx_t F2_LARGE = IDX_W'(480);

    // pi(i+1) - pi(i) = f1 + f2*(2i+1); starting at i=0 it is f1+f2 and it
    // grows by 2*f2 every step, so two modular adders replace the multiply.
    localparam idx_t G0_SMALL = IDX_W'((1056'(F1_SMALL) + 1056'(F2_SMALL)) % 1056'(K_SMALL));
    localparam idx_t G0_LARGE = IDX_W'((1056'(F1_LARGE) + 1056'(F2_LARGE)) % 1056'(K_LARGE));
    localparam idx_t D_SMALL  = IDX_W'((1056'(F2_SMALL) * 2) % 1056'(K_SMALL));
    localparam idx_t D_LARGE  = IDX_W'((1056'(F2_LARGE) * 2) % 1056'(K_LARGE));

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Block-size select: 0 selects K_SMALL, 1 selects K_LARGE.
    function automatic idx_t sel_k(input logic k_sel);
        return k_sel ? K_LARGE : K_SMALL;
    endfunction

    function automatic idx_t sel_g0(input logic k_sel);
        return k_sel ? G0_LARGE : G0_SMALL;
    endfunction

    function automatic idx_t sel_d(input logic k_sel);
        return k_sel ? D_LARGE : D_SMALL;
    endfunction

endpackage

// File: rtl/qpp_mod_add.sv
// ---------------------------------------------------------------------------
// qpp_mod_add
//
// Modular adder: sum = (a + b) mod modulus, for operands already reduced
// below the modulus. With both operands < modulus the raw sum is < 2*modulus,
// so a single conditional subtract is a full reduction. The largest sum
// (6143 + 6143) fits in 14 bits, so no carry bit is needed.
//
// Ports:
//   a        in  14  first operand, 0..modulus-1
//   b        in  14  second operand, 0..modulus-1
//   modulus  in  14  block size K
//   sum      out 14  (a + b) mod modulus
// ---------------------------------------------------------------------------
module qpp_mod_add
    import qpp_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    input  logic [IDX_W-1:0] modulus,
    output logic [IDX_W-1:0] sum
);

    logic [IDX_W-1:0] raw;

    assign raw = a + b;
    assign sum = (raw >= modulus) ? (raw - modulus) : raw;

endmodule

// File: rtl/qpp_index_stream.sv
// ---------------------------------------------------------------------------
// qpp_index_stream
//
// Sequential QPP index generator. After a start request it emits, one pair
// per clock, the natural index i and the interleaved index
// pi(i) = (f1*i + f2*i^2) mod K, for i = 0..K-1, with K chosen by k at
// start. pi is built incrementally: pi += g, g += 2*f2, all modulo K.
//
// Handshake: ready is a start request, taken only while the generator is
// idle; valid marks each of the K consecutive output pairs, last marks the
// final pair (i = K-1). There is no back-pressure: once started, a block
// streams to completion unless reset aborts it.
//
// Ports:
//   clock   in  1   system clock, rising edge
//   reset   in  1   synchronous active-low reset
//   k       in  1   block size select (0: K=1056, 1: K=6144), taken at start
//   ready   in  1   start request, honoured only when idle
//   idx     out 14  natural index i
//   pi_idx  out 14  interleaved index pi(i)
//   valid   out 1   idx/pi_idx meaningful this cycle
//   last    out 1   final pair of the block
//   busy    out 1   block in progress (aligned with valid)
// ---------------------------------------------------------------------------
module qpp_index_stream
    import qpp_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             k,
    input  logic             ready,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] pi_idx,
    output logic             valid,
    output logic             last,
    output logic             busy
);

    // Generator state. The output registers below trail this by one cycle,
    // which gives the one-cycle start latency and keeps every output a
    // plain flop.
    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] pi_q, pi_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic             k_r_q, k_r_d;

    logic [IDX_W-1:0] k_mod;
    logic [IDX_W-1:0] d_step;
    logic [IDX_W-1:0] pi_next;
    logic [IDX_W-1:0] g_next;
    logic             final_pair;

    // Constants follow the latched select, so k may change freely mid-block.
    assign k_mod      = sel_k(k_r_q);
    assign d_step     = sel_d(k_r_q);
    assign final_pair = (i_q == (k_mod - IDX_W'(1)));

    qpp_mod_add u_pi_add (
        .a       (pi_q),
        .b       (g_q),
        .modulus (k_mod),
        .sum     (pi_next)
    );

    qpp_mod_add u_g_add (
        .a       (g_q),
        .b       (d_step),
        .modulus (k_mod),
        .sum     (g_next)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        pi_d    = pi_q;
        g_d     = g_q;
        k_r_d   = k_r_q;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    k_r_d   = k;
                    i_d     = '0;
                    pi_d    = '0;
                    g_d     = sel_g0(k);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (final_pair) begin
                    // Park the counters at zero so the idle outputs read 0.
                    i_d     = '0;
                    pi_d    = '0;
                    g_d     = '0;
                    state_d = IDLE;
                end else begin
                    i_d  = i_q + IDX_W'(1);
                    pi_d = pi_next;
                    g_d  = g_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Generator registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            pi_q    <= '0;
            g_q     <= '0;
            k_r_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            k_r_q   <= k_r_d;
        end
    end

    // Output registers: present the pair the generator holds this cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx    <= '0;
            pi_idx <= '0;
            valid  <= 1'b0;
            last   <= 1'b0;
            busy   <= 1'b0;
        end else if (state_q == RUN) begin
            idx    <= i_q;
            pi_idx <= pi_q;
            valid  <= 1'b1;
            last   <= final_pair;
            busy   <= 1'b1;
        end else begin
            idx    <= '0;
            pi_idx <= '0;
            valid  <= 1'b0;
            last   <= 1'b0;
            busy   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qpp_index_stream.sv
// ---------------------------------------------------------------------------
// tb_qpp_index_stream
//
// Directed bench for qpp_index_stream. Expected pi values come from the
// closed-form polynomial (f1*i + f2*i^2) mod K evaluated in 64-bit integers,
// plus a table of hand-computed anchor pairs.
// ---------------------------------------------------------------------------
module tb_qpp_index_stream;

  logic        clock;
  logic        reset;
  logic        k;
  logic        ready;
  logic [13:0] idx;
  logic [13:0] pi_idx;
  logic        valid;
  logic        last;
  logic        busy;

  qpp_index_stream dut (
    .clock  (clock),
    .reset  (reset),
    .k      (k),
    .ready  (ready),
    .idx    (idx),
    .pi_idx (pi_idx),
    .valid  (valid),
    .last   (last),
    .busy   (busy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];

  int cap_n;
  int cap_idx  [0:6143];
  int cap_pi   [0:6143];
  int cap_last [0:6143];
  int cap_busy [0:6143];
  int sav_pi   [0:1055];

  typedef struct {
    int k;
    int i;
    int pi;
    int last;
  } vec_t;

  vec_t vecs [0:10];

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint k_of(input int kk);
    return (kk != 0) ? 64'd6144 : 64'd1056;
  endfunction

  function automatic int pi_model(input int kk, input int i);
    longint kv, f1, f2, ii;
    kv = k_of(kk);
    f1 = (kk != 0) ? 64'd263 : 64'd17;
    f2 = (kk != 0) ? 64'd480 : 64'd66;
    ii = longint'(i);
    return int'((f1 * ii + f2 * ii * ii) % kv);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_last"}, int'(last), 0);
    check({tag, "_idx"}, int'(idx), 0);
    check({tag, "_pi"}, int'(pi_idx), 0);
  endtask

  // Sample on negedges; skip leading idle cycles (counted), record the valid
  // run, stop at the first idle cycle after it or when the budget runs out.
  task automatic capture(input int max_cycles, output int idle_cnt);
    cap_n    = 0;
    idle_cnt = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clock);
      if (valid) begin
        if (cap_n < 6144) begin
          cap_idx[cap_n]  = int'(idx);
          cap_pi[cap_n]   = int'(pi_idx);
          cap_last[cap_n] = int'(last);
          cap_busy[cap_n] = int'(busy);
        end
        cap_n++;
      end else if (cap_n > 0) begin
        break;
      end else begin
        idle_cnt++;
      end
    end
  endtask

  task automatic verify_block(input string tag, input int kk, input int len);
    int kv;
    int n;
    logic [13:0] e;
    kv = int'(k_of(kk));
    check({tag, "_len"}, cap_n, len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(14'(pi_model(kk, i)));
    n = (cap_n < len) ? cap_n : len;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, cap_idx[i], i);
      check({tag, "_pi"}, cap_pi[i], int'(e));
      check({tag, "_last"}, cap_last[i], (i == kv - 1) ? 1 : 0);
      check({tag, "_busy"}, cap_busy[i], 1);
    end
  endtask

  task automatic apply_table(input int kk);
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].k == kk) begin
        if (vecs[v].i < cap_n) begin
          check("tbl_idx", cap_idx[vecs[v].i], vecs[v].i);
          check("tbl_pi", cap_pi[vecs[v].i], vecs[v].pi);
          check("tbl_last", cap_last[vecs[v].i], vecs[v].last);
        end else begin
          check("tbl_missing", cap_n, vecs[v].i + 1);
        end
      end
    end
  endtask

  // One-cycle start request; the following negedge must still be idle.
  task automatic start_pulse(input int kk);
    @(negedge clock);
    k     = (kk != 0);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    check("start_latency_valid", int'(valid), 0);
  endtask

  // ---------------- main test ----------------
  initial begin : main
    int idle;
    int reached;
    int diffs;
    int distinct;
    int in_range;
    bit seen [0:6143];

    vecs[0]  = '{0, 0, 0, 0};
    vecs[1]  = '{0, 1, 83, 0};
    vecs[2]  = '{0, 2, 298, 0};
    vecs[3]  = '{0, 3, 645, 0};
    vecs[4]  = '{0, 4, 68, 0};
    vecs[5]  = '{0, 1055, 49, 1};
    vecs[6]  = '{1, 0, 0, 0};
    vecs[7]  = '{1, 1, 743, 0};
    vecs[8]  = '{1, 2, 2446, 0};
    vecs[9]  = '{1, 3, 5109, 0};
    vecs[10] = '{1, 6143, 217, 1};

    reset = 1'b0;
    ready = 1'b1;
    k     = 1'b0;

    // Reset dominates a held start request.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_idle_outputs("reset");
    end
    ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("post_reset");

    // K=1056 block.
    start_pulse(0);
    capture(7000, idle);
    check("k1056_first_latency", idle, 0);
    verify_block("k1056", 0, 1056);
    apply_table(0);
    check_idle_outputs("k1056_end");

    // K=6144 block with permutation check.
    start_pulse(1);
    capture(7000, idle);
    check("k6144_first_latency", idle, 0);
    verify_block("k6144", 1, 6144);
    apply_table(1);
    for (int i = 0; i < 6144; i++) seen[i] = 1'b0;
    distinct = 0;
    in_range = 1;
    for (int i = 0; i < cap_n && i < 6144; i++) begin
      if (cap_pi[i] >= 6144) in_range = 0;
      else if (!seen[cap_pi[i]]) begin
        seen[cap_pi[i]] = 1'b1;
        distinct++;
      end
    end
    check("k6144_perm_range", in_range, 1);
    check("k6144_perm_distinct", distinct, 6144);

    // Start request and k change during a run are ignored.
    start_pulse(0);
    reached = 0;
    fork
      capture(7000, idle);
      begin
        for (int c = 0; c < 2000; c++) begin
          @(negedge clock);
          if (valid && idx == 14'd500) begin
            reached = 1;
            break;
          end
        end
        k     = 1'b1;
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
      end
    join
    check("ignore_reached_500", reached, 1);
    verify_block("ignore", 0, 1056);
    apply_table(0);
    repeat (2) @(negedge clock);
    check_idle_outputs("ignore_no_restart");

    // Reset in the middle of a K=6144 block.
    start_pulse(1);
    reached = 0;
    fork
      capture(7000, idle);
      begin
        for (int c = 0; c < 2000; c++) begin
          @(negedge clock);
          if (valid && idx == 14'd300) begin
            reached = 1;
            break;
          end
        end
        reset = 1'b0;
      end
    join
    check("abort_reached_300", reached, 1);
    check_idle_outputs("abort");
    verify_block("abort", 1, 301);
    @(negedge clock);
    check_idle_outputs("abort_hold");
    reset = 1'b1;
    start_pulse(0);
    capture(7000, idle);
    check("restart_latency", idle, 0);
    verify_block("restart", 0, 1056);

    // Back-to-back blocks with ready held high.
    @(negedge clock);
    k     = 1'b0;
    ready = 1'b1;
    capture(7000, idle);
    check("b2b_first_latency", idle, 1);
    verify_block("b2b1", 0, 1056);
    for (int i = 0; i < 1056; i++) sav_pi[i] = cap_pi[i];
    capture(7000, idle);
    // capture already consumed the one idle cycle that ended block 1
    check("b2b_gap", idle + 1, 1);
    verify_block("b2b2", 0, 1056);
    diffs = 0;
    for (int i = 0; i < 1056 && i < cap_n; i++)
      if (cap_pi[i] != sav_pi[i]) diffs++;
    check("b2b_identical", diffs, 0);
    ready = 1'b0;
    capture(2000, idle);
    check("b2b_third_len", cap_n, 1056);
    repeat (3) @(negedge clock);
    check_idle_outputs("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qpp_index_stream.md
# qpp_index_stream

Sequential QPP (quadratic permutation polynomial) index generator for the turbo-coder interleaver datapath. On a start request it emits, one pair per clock, the natural-order bit index i and the interleaved index pi(i) = (f1·i + f2·i²) mod K for the selected block size (K = 1056 or 6144). These drive the select inputs of the two 6144:1 output multiplexers, producing the in-order (c_i) and interleaved (c'_i = c_pi(i)) bit-serial streams. It replaces a fully combinational 6144-bit permutation with an incremental-arithmetic counter.

## Interface
- No parameters; K, f1, f2 are fixed constants from the shared package.
- clock  in  1  single system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
- k  in  1  block size select: 0 = K 1056 (f1 17, f2 66), 1 = K 6144 (f1 263, f2 480); sampled only at start
- ready  in  1  start request; honoured only in IDLE
- idx  out  14  natural index i, 0..K-1
- pi_idx  out  14  interleaved index pi(i), 0..K-1
- valid  out  1  idx/pi_idx are meaningful this cycle
- last  out  1  high with valid on the final pair (i = K-1)
- busy  out  1  high while RUN

## Operation
- States: IDLE, RUN.
- IDLE: valid=0, last=0, busy=0, idx=0, pi_idx=0. If ready=1 at an edge: latch k into k_r, load i=0, pi=0, g=g0(k), enter RUN.
- RUN, each edge: output pair (i, pi) is valid; then i←i+1, pi←(pi+g) mod K, g←(g+d) mod K.
  - g0 = (f1+f2) mod K: 83 for K=1056, 743 for K=6144.
  - d = 2·f2 mod K: 132 for K=1056, 960 for K=6144.
- When i = K-1 is presented (last=1), next edge returns to IDLE.
- Modular add: operands both < K; 14-bit sum s; result = s ≥ K ? s−K : s. No multipliers.
- ready while in RUN: ignored, no restart. k changes while in RUN: ignored; k_r governs the whole block.
- ready held high continuously: a new block starts on the edge after IDLE is re-entered, giving one idle cycle between blocks.

## Timing
- Reset (reset=0 at an edge): state IDLE, all outputs 0, internal i/pi/g/k_r cleared. Reset dominates ready. Reset during RUN aborts the block immediately, with no further valid.
- Latency: ready sampled high at edge N gives valid=1 with idx=0, pi_idx=0 after edge N+1.
- Stream length is exactly K consecutive valid cycles, with no gaps. last is high only on the Kth.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package qpp_pkg holds:
  - K_SMALL=1056 and K_LARGE=6144
  - F1/F2 for each size
  - derived G0 and D constants
  - IDX_W=14
  - the state enum {IDLE, RUN}
- One sub-module is natural: qpp_mod_add, which takes a, b, and K and returns (a+b) mod K. It is instantiated twice, once for the pi update and once for the g update.
- The top level holds the FSM, the i counter, the registered outputs, and constant selection by k_r.

## Test plan
- Reset: hold reset=0 for 3 cycles with ready=1 → valid=0, busy=0, idx=pi_idx=0 throughout.
- K=1056 start: k=0, 1-cycle ready pulse.
  - First pairs (i,pi): (0,0), (1,83), (2,298), (3,645), (4,68).
  - Final pair (1055,49) with last=1.
  - Exactly 1056 valid cycles, then IDLE.
- K=6144 start: k=1.
  - First pairs: (0,0), (1,743), (2,2446), (3,5109).
  - Final pair (6143,217) with last=1.
  - Collect all 6144 pi values and check they form a permutation of 0..6143.
- Ignored inputs: during a K=1056 run, toggle k to 1 and pulse ready at i=500 → sequence unchanged, still ends at (1055,49).
- Mid-run reset: assert reset=0 at i=300 in a K=6144 run → outputs 0 and IDLE on the next edge. A new ready then restarts at (0,0).
- Back-to-back: ready held high across two K=1056 blocks → one idle cycle between last and the next (0,0). The second block is identical to the first.
